updown_counter_bank: RTL and testbench
======================================

# updown_counter_bank

Bank of CHANNELS independent, parametrised up/down counters with per-channel programmable limit, wrap or saturate mode, synchronous load, terminal count and optional cascading of each channel from its lower neighbour's carry. It serves as the general-purpose timer/event-counter primitive for the data-integrity blocks. It replaces single fixed-range counters, and embedded formal properties can be compiled in for standalone proof.

## Interface
- WIDTH, 8, bits per channel counter.
- CHANNELS, 4, number of counter channels (>=1).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  CHANNELS  per-channel step enable.
- up_down  in  CHANNELS  direction, 1=up, 0=down.
- load  in  CHANNELS  synchronous load strobe.
- load_value  in  CHANNELS*WIDTH  load data; channel i at [i*WIDTH +: WIDTH].
- limit  in  CHANNELS*WIDTH  per-channel maximum; count range is 0..limit.
- sat_mode  in  CHANNELS  1=saturate at boundary, 0=wrap.
- cascade  in  CHANNELS  bit i (i>=1) gates channel i on carry of channel i-1; bit 0 ignored.
- count  out  CHANNELS*WIDTH  registered count values.
- tc  out  CHANNELS  terminal count, combinational from count/up_down/limit.
- wrap  out  CHANNELS  registered one-cycle pulse, channel wrapped.

## Operation
- step[i] = en[i] && (i==0 || !cascade[i] || carry[i-1]).
- tc[i] = (up_down[i] && count[i]==limit[i]) || (!up_down[i] && count[i]==0).
- carry[i] = step[i] && !load[i] && tc[i] (combinational, ripples up the chain; asserted in both modes).
- Next-state priority per channel:
  - load[i]: count <= min(load_value[i], limit[i]) (load above limit clamps to limit). Load ignores en and cascade.
  - step[i] and count[i] > limit[i] (limit lowered below count): count <= limit[i], both modes and directions; tc=0, carry=0.
  - step[i], up, count<limit: count+1. Down, count>0: count-1.
  - step[i] at boundary, wrap mode: up limit->0; down 0->limit.
  - step[i] at boundary, saturate mode: count holds.
  - otherwise count holds.
- wrap[i] <= carry[i] && !sat_mode[i]; low otherwise, including on load.
- limit=0: count pinned to 0, tc=1 every cycle, and every step in either direction is a carry.
- Arithmetic is WIDTH-bit unsigned; no intermediate overflow, since +1 only when count<limit and -1 only when count>0.

## Timing
- Reset (rst_n low, asynchronous): count=0 all channels, wrap=0. Deassertion takes effect at the first clk rising edge with rst_n high.
- Reset mid-count clears immediately. No pending load or step survives.
- Latency: load/en/step to count change, 1 cycle. wrap pulses in the same cycle the post-wrap count is visible.
- tc follows count, up_down and limit combinationally, with zero latency.
- Cascade carry is same-cycle: channel 0 wrap and channel 1 increment land on the same edge.
- A direction change takes effect on the next step. tc re-evaluates immediately.

## Configuration
- UDCNT_BANK_SVA_EN defined: embedded assertions are compiled in, per channel:
  - count<=limit after any load or step;
  - reset yields 0;
  - +1/-1 correctness;
  - hold when !step && !load;
  - load clamp value;
  - wrap targets;
  - saturate hold;
  - tc equation;
  - wrap pulse one cycle wide.
  - Covers for:
    - wrap up and wrap down;
    - saturation;
    - load while stepping;
    - two-level cascade carry;
    - limit lowered below count.
  - All assertions are disabled while !rst_n.
- Undefined: pure RTL, no assertion or cover code; functional behaviour identical.

## Test plan
- WIDTH=4, CHANNELS=2. Reset, then en[0]=1 up with limit=9 and wrap mode for 10 cycles -> count0 goes 1..9 then 0; wrap[0] pulses once with count0=0; tc[0]=1 while count0=9.
- Same setup with sat_mode=1 for 12 cycles -> count0 sticks at 9; wrap stays 0; tc stays 1.
- Down, wrap mode, limit=5, load 0 -> next step gives 5, wrap pulses; down, saturate from 0 -> holds 0.
- Cascade[1]=1, en=2'b11, both up, limits 3/3 -> count1 increments only on cycles where count0 goes 3->0; after 16 steps both reach 0 together and wrap=2'b11.
- Simultaneous load=1, en=1 with load_value=12, limit=9 -> count=9 (load wins, clamped); no wrap.
- count=8, limit changed to 4, step -> count=4. Assert rst_n=0 mid-sequence asynchronously -> count=0 and wrap=0 before the next clk edge.

Source files
------------

// File: rtl/updown_counter_bank.sv
// updown_counter_bank: a bank of CHANNELS independent up/down counters.
// Each channel has its own programmable limit (range 0..limit), wrap or
// saturate behaviour, a synchronous clamped load and a combinational
// terminal count. A channel can also be cascaded so that it steps only
// when its lower neighbour carries.
// Optional macro: UDCNT_BANK_SVA_EN compiles in the embedded property
// checker (udcnt_bank_sva). When it is undefined the RTL is identical
// and carries no assertion code.
module updown_counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS-1:0]       i_en,
  input  logic [CHANNELS-1:0]       i_up_down,
  input  logic [CHANNELS-1:0]       i_load,
  input  logic [CHANNELS*WIDTH-1:0] i_load_value,
  input  logic [CHANNELS*WIDTH-1:0] i_limit,
  input  logic [CHANNELS-1:0]       i_sat_mode,
  input  logic [CHANNELS-1:0]       i_cascade,
  output logic [CHANNELS*WIDTH-1:0] o_count,
  output logic [CHANNELS-1:0]       o_tc,
  output logic [CHANNELS-1:0]       o_wrap
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

  // Channel 0 has no lower neighbour, so its cascade bit has no meaning.
  logic w_unused_cascade0;
  assign w_unused_cascade0 = i_cascade[0];

`ifdef UDCNT_BANK_SVA_EN
  logic [CHANNELS-1:0] w_step_v;
  logic [CHANNELS-1:0] w_carry_v;
`endif

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : gen_ch
    logic [WIDTH-1:0] w_cnt;
    logic [WIDTH-1:0] w_lim;
    logic [WIDTH-1:0] w_ldv;
    logic [WIDTH-1:0] w_next;
    logic             w_chain_ok;
    logic             w_step;
    logic             w_tc;
    logic             w_carry;
    logic             w_wrap_next;
    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;

    assign w_cnt = r_cnt;
    assign w_lim = i_limit[g*WIDTH +: WIDTH];
    assign w_ldv = i_load_value[g*WIDTH +: WIDTH];

    // The carry chain ripples combinationally from the lower neighbour.
    if (g == 0) begin : gen_head
      assign w_chain_ok = 1'b1;
    end else begin : gen_link
      assign w_chain_ok = !i_cascade[g] || gen_ch[g-1].w_carry;
    end

    assign w_step      = i_en[g] && w_chain_ok;
    // A count above a freshly lowered limit matches neither term, so tc is 0.
    assign w_tc        = (i_up_down[g] && (w_cnt == w_lim)) ||
                         (!i_up_down[g] && (w_cnt == ZERO));
    assign w_carry     = w_step && !i_load[g] && w_tc;
    assign w_wrap_next = w_carry && !i_sat_mode[g];

    // Next count: clamped load first, then pull-back, step, wrap or hold.
    always_comb begin
      w_next = w_cnt;
      if (i_load[g]) begin
        w_next = (w_ldv > w_lim) ? w_lim : w_ldv;
      end else if (w_step) begin
        if (w_cnt > w_lim) begin
          w_next = w_lim;
        end else if (i_up_down[g]) begin
          if (w_cnt < w_lim) begin
            w_next = w_cnt + ONE;
          end else if (!i_sat_mode[g]) begin
            w_next = ZERO;
          end else begin
            w_next = w_cnt;
          end
        end else begin
          if (w_cnt != ZERO) begin
            w_next = w_cnt - ONE;
          end else if (!i_sat_mode[g]) begin
            w_next = w_lim;
          end else begin
            w_next = w_cnt;
          end
        end
      end else begin
        w_next = w_cnt;
      end
    end

    // Count and wrap-pulse registers; reset clears both immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cnt  <= ZERO;
        r_wrap <= 1'b0;
      end else begin
        r_cnt  <= w_next;
        r_wrap <= w_wrap_next;
      end
    end

    assign o_count[g*WIDTH +: WIDTH] = r_cnt;
    assign o_tc[g]                   = w_tc;
    assign o_wrap[g]                 = r_wrap;

`ifdef UDCNT_BANK_SVA_EN
    assign w_step_v[g]  = w_step;
    assign w_carry_v[g] = w_carry;
`endif
  end

`ifdef UDCNT_BANK_SVA_EN
  udcnt_bank_sva #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_sva (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_up_down   (i_up_down),
    .i_load      (i_load),
    .i_load_value(i_load_value),
    .i_limit     (i_limit),
    .i_sat_mode  (i_sat_mode),
    .i_cascade   (i_cascade),
    .i_step      (w_step_v),
    .i_carry     (w_carry_v),
    .i_count     (o_count),
    .i_tc        (o_tc),
    .i_wrap      (o_wrap)
  );
`endif

endmodule

`ifdef UDCNT_BANK_SVA_EN
// Property checker for the counter bank, one set of properties per channel.
module udcnt_bank_sva #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  input logic [CHANNELS-1:0]       i_up_down,
  input logic [CHANNELS-1:0]       i_load,
  input logic [CHANNELS*WIDTH-1:0] i_load_value,
  input logic [CHANNELS*WIDTH-1:0] i_limit,
  input logic [CHANNELS-1:0]       i_sat_mode,
  input logic [CHANNELS-1:0]       i_cascade,
  input logic [CHANNELS-1:0]       i_step,
  input logic [CHANNELS-1:0]       i_carry,
  input logic [CHANNELS*WIDTH-1:0] i_count,
  input logic [CHANNELS-1:0]       i_tc,
  input logic [CHANNELS-1:0]       i_wrap
);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : gen_chk
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] v;
    logic             ld;
    logic             st;
    assign c  = i_count[g*WIDTH +: WIDTH];
    assign l  = i_limit[g*WIDTH +: WIDTH];
    assign v  = i_load_value[g*WIDTH +: WIDTH];
    assign ld = i_load[g];
    assign st = i_step[g] && !i_load[g];

    a_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (ld || i_step[g]) |=> (c <= $past(l)));
    a_reset: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      $rose(i_rst_n) |-> (c == ZERO) && !i_wrap[g]);
    a_inc: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (st && i_up_down[g] && (c < l)) |=> (c == $past(c) + ONE));
    a_dec: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (st && !i_up_down[g] && (c != ZERO) && (c <= l)) |=> (c == $past(c) - ONE));
    a_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (!i_step[g] && !ld) |=> (c == $past(c)));
    a_load: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      ld |=> (c == (($past(v) > $past(l)) ? $past(l) : $past(v))));
    a_wrap_up: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_carry[g] && !i_sat_mode[g] && i_up_down[g]) |=> (c == ZERO));
    a_wrap_dn: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_carry[g] && !i_sat_mode[g] && !i_up_down[g]) |=> (c == $past(l)));
    a_sat: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_carry[g] && i_sat_mode[g]) |=> (c == $past(c)));
    a_tc: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_tc[g] == ((i_up_down[g] && (c == l)) || (!i_up_down[g] && (c == ZERO))));
    a_wrap_pulse: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      1'b1 |=> (i_wrap[g] == $past(i_carry[g] && !i_sat_mode[g])));

    c_wrap_up: cover property (@(posedge i_clk) disable iff (!i_rst_n)
      i_carry[g] && !i_sat_mode[g] && i_up_down[g]);
    c_wrap_dn: cover property (@(posedge i_clk) disable iff (!i_rst_n)
      i_carry[g] && !i_sat_mode[g] && !i_up_down[g]);
    c_sat: cover property (@(posedge i_clk) disable iff (!i_rst_n)
      i_carry[g] && i_sat_mode[g]);
    c_load_step: cover property (@(posedge i_clk) disable iff (!i_rst_n)
      ld && i_step[g]);
    c_lowered: cover property (@(posedge i_clk) disable iff (!i_rst_n)
      st && (c > l));
    if (g >= 1) begin : gen_casc
      c_cascade2: cover property (@(posedge i_clk) disable iff (!i_rst_n)
        i_cascade[g] && i_carry[g] && i_carry[g-1]);
    end
  end
endmodule
`endif

// File: tb/tb_updown_counter_bank.sv
// Directed testbench for updown_counter_bank with WIDTH=4, CHANNELS=2.
module tb_updown_counter_bank;
  logic       clk;
  logic       rst_n;
  logic [1:0] en;
  logic [1:0] up_down;
  logic [1:0] load;
  logic [7:0] load_value;
  logic [7:0] limit;
  logic [1:0] sat_mode;
  logic [1:0] cascade;
  logic [7:0] count;
  logic [1:0] tc;
  logic [1:0] wrap;

  int checks = 0;
  int errors = 0;

  updown_counter_bank #(.WIDTH(4), .CHANNELS(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_up_down   (up_down),
    .i_load      (load),
    .i_load_value(load_value),
    .i_limit     (limit),
    .i_sat_mode  (sat_mode),
    .i_cascade   (cascade),
    .o_count     (count),
    .o_tc        (tc),
    .o_wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 2'b00; up_down = 2'b00; load = 2'b00;
    load_value = 8'h00; limit = 8'h00; sat_mode = 2'b00; cascade = 2'b00;
    cyc(); cyc();
    checks++;
    if (count !== 8'h00) begin errors++; $display("FAIL reset_count got=%h exp=%h", count, 8'h00); end
    checks++;
    if (wrap !== 2'b00) begin errors++; $display("FAIL reset_wrap got=%b exp=%b", wrap, 2'b00); end
    checks++;
    if (tc !== 2'b11) begin errors++; $display("FAIL reset_tc got=%b exp=%b", tc, 2'b11); end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (count !== 8'h00) begin errors++; $display("FAIL post_reset_count got=%h exp=%h", count, 8'h00); end
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_c;
    limit = 8'h09; up_down = 2'b01; sat_mode = 2'b00; en = 2'b01;
    #1;
    checks++;
    if (tc[0] !== 1'b0) begin errors++; $display("FAIL wrap_up_tc0_start got=%b exp=%b", tc[0], 1'b0); end
    for (int k = 1; k <= 10; k++) begin
      cyc();
      exp_c = 4'(k % 10);
      checks++;
      if (count[3:0] !== exp_c) begin errors++; $display("FAIL wrap_up_count k=%0d got=%h exp=%h", k, count[3:0], exp_c); end
      checks++;
      if (wrap[0] !== (k == 10)) begin errors++; $display("FAIL wrap_up_wrap k=%0d got=%b exp=%b", k, wrap[0], (k == 10)); end
      checks++;
      if (tc[0] !== (exp_c == 4'd9)) begin errors++; $display("FAIL wrap_up_tc k=%0d got=%b exp=%b", k, tc[0], (exp_c == 4'd9)); end
    end
    en = 2'b00;
  endtask

  task automatic test_saturate();
    logic [3:0] exp_c;
    sat_mode = 2'b01; en = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp_c = (k > 9) ? 4'd9 : 4'(k);
      checks++;
      if (count[3:0] !== exp_c) begin errors++; $display("FAIL sat_count k=%0d got=%h exp=%h", k, count[3:0], exp_c); end
      checks++;
      if (wrap[0] !== 1'b0) begin errors++; $display("FAIL sat_wrap k=%0d got=%b exp=%b", k, wrap[0], 1'b0); end
      checks++;
      if (tc[0] !== (exp_c == 4'd9)) begin errors++; $display("FAIL sat_tc k=%0d got=%b exp=%b", k, tc[0], (exp_c == 4'd9)); end
    end
    en = 2'b00;
  endtask

  task automatic test_down();
    limit = 8'h05; load_value = 8'h00; load = 2'b01; sat_mode = 2'b00; en = 2'b00;
    cyc();
    checks++;
    if (count[3:0] !== 4'd0) begin errors++; $display("FAIL down_load0 got=%h exp=%h", count[3:0], 4'd0); end
    load = 2'b00; up_down = 2'b00; en = 2'b01;
    #1;
    checks++;
    if (tc[0] !== 1'b1) begin errors++; $display("FAIL down_tc_at0 got=%b exp=%b", tc[0], 1'b1); end
    cyc();
    checks++;
    if (count[3:0] !== 4'd5) begin errors++; $display("FAIL down_wrap_count got=%h exp=%h", count[3:0], 4'd5); end
    checks++;
    if (wrap[0] !== 1'b1) begin errors++; $display("FAIL down_wrap_pulse got=%b exp=%b", wrap[0], 1'b1); end
    cyc();
    checks++;
    if (count[3:0] !== 4'd4) begin errors++; $display("FAIL down_dec got=%h exp=%h", count[3:0], 4'd4); end
    checks++;
    if (wrap[0] !== 1'b0) begin errors++; $display("FAIL down_wrap_clear got=%b exp=%b", wrap[0], 1'b0); end
    load = 2'b01;
    cyc();
    load = 2'b00; sat_mode = 2'b01;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (count[3:0] !== 4'd0) begin errors++; $display("FAIL down_sat_count k=%0d got=%h exp=%h", k, count[3:0], 4'd0); end
      checks++;
      if (wrap[0] !== 1'b0 || tc[0] !== 1'b1) begin errors++; $display("FAIL down_sat_flags k=%0d got=%b%b exp=01", k, wrap[0], tc[0]); end
    end
    en = 2'b00; sat_mode = 2'b00;
  endtask

  task automatic test_cascade();
    logic [7:0] exp_c;
    logic [1:0] exp_w;
    load_value = 8'h00; load = 2'b11; en = 2'b00;
    cyc();
    load = 2'b00; limit = 8'h33; up_down = 2'b11; sat_mode = 2'b00;
    cascade = 2'b10; en = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      exp_c = {4'((k / 4) % 4), 4'(k % 4)};
      exp_w = {(k == 16), (k % 4 == 0)};
      checks++;
      if (count !== exp_c) begin errors++; $display("FAIL cascade_count k=%0d got=%h exp=%h", k, count, exp_c); end
      checks++;
      if (wrap !== exp_w) begin errors++; $display("FAIL cascade_wrap k=%0d got=%b exp=%b", k, wrap, exp_w); end
    end
    en = 2'b00; cascade = 2'b00;
  endtask

  task automatic test_load_priority();
    limit = 8'h39; load_value = 8'h09; load = 2'b01; en = 2'b00; up_down = 2'b01;
    cyc();
    checks++;
    if (count[3:0] !== 4'd9) begin errors++; $display("FAIL ldpri_preload got=%h exp=%h", count[3:0], 4'd9); end
    load_value = 8'h0C; en = 2'b01;
    cyc();
    checks++;
    if (count[3:0] !== 4'd9) begin errors++; $display("FAIL ldpri_clamp got=%h exp=%h", count[3:0], 4'd9); end
    checks++;
    if (wrap !== 2'b00) begin errors++; $display("FAIL ldpri_wrap got=%b exp=%b", wrap, 2'b00); end
    load = 2'b00; en = 2'b00;
  endtask

  task automatic test_limit_lower();
    limit = 8'h39; load_value = 8'h08; load = 2'b01; en = 2'b00; up_down = 2'b01;
    cyc();
    load = 2'b00; limit = 8'h34; en = 2'b01;
    #1;
    checks++;
    if (tc[0] !== 1'b0) begin errors++; $display("FAIL lower_tc_above got=%b exp=%b", tc[0], 1'b0); end
    cyc();
    checks++;
    if (count[3:0] !== 4'd4) begin errors++; $display("FAIL lower_up got=%h exp=%h", count[3:0], 4'd4); end
    checks++;
    if (wrap[0] !== 1'b0 || tc[0] !== 1'b1) begin errors++; $display("FAIL lower_up_flags got=%b%b exp=01", wrap[0], tc[0]); end
    limit = 8'h39; load = 2'b01; en = 2'b00;
    cyc();
    load = 2'b00; limit = 8'h34; up_down = 2'b00; en = 2'b01;
    cyc();
    checks++;
    if (count[3:0] !== 4'd4 || wrap[0] !== 1'b0) begin errors++; $display("FAIL lower_down got=%h/%b exp=4/0", count[3:0], wrap[0]); end
    en = 2'b00;
  endtask

  task automatic test_limit_zero();
    limit = 8'h09; up_down = 2'b10; sat_mode = 2'b00; cascade = 2'b00; en = 2'b10;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) up_down = 2'b00;
      cyc();
      checks++;
      if (count[7:4] !== 4'd0 || wrap[1] !== 1'b1 || tc[1] !== 1'b1) begin
        errors++; $display("FAIL limit0 k=%0d got=%h/%b/%b exp=0/1/1", k, count[7:4], wrap[1], tc[1]);
      end
    end
    en = 2'b00;
  endtask

  task automatic test_reset_async();
    limit = 8'h39; load_value = 8'h29; load = 2'b11; en = 2'b00; up_down = 2'b11;
    sat_mode = 2'b00; cascade = 2'b00;
    cyc();
    load = 2'b00; en = 2'b01;
    cyc();
    checks++;
    if (count !== 8'h20 || wrap !== 2'b01) begin errors++; $display("FAIL areset_setup got=%h/%b exp=20/01", count, wrap); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 8'h00) begin errors++; $display("FAIL areset_count got=%h exp=%h", count, 8'h00); end
    checks++;
    if (wrap !== 2'b00) begin errors++; $display("FAIL areset_wrap got=%b exp=%b", wrap, 2'b00); end
    cyc();
    en = 2'b00;
    rst_n = 1'b1;
    cyc();
    checks++;
    if (count !== 8'h00 || wrap !== 2'b00) begin errors++; $display("FAIL areset_release got=%h/%b exp=00/00", count, wrap); end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_saturate();
    test_down();
    test_cascade();
    test_load_priority();
    test_limit_lower();
    test_limit_zero();
    test_reset_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
